// File: rtl/router_egress_arbiter.sv
// rtl/router_egress_arbiter.sv - packet round-robin arbiter draining three FIFOs onto one egress byte link
// Optional watchdog that abandons a stalled packet: define ROUTER_ARB_TIMEOUT_EN.
module router_egress_arbiter #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 30
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [2:0]    fifo_empty,
    input  logic [DW-1:0] fifo_dout_0,
    input  logic [DW-1:0] fifo_dout_1,
    input  logic [DW-1:0] fifo_dout_2,
    input  logic          out_ready,
    output logic [2:0]    read_enb,
    output logic [DW-1:0] dout,
    output logic          vout,
    output logic          sop,
    output logic          eop,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          abort
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_HWAIT, S_BODY, S_DRAIN} state_t;

    localparam logic [DW-2:0] REM_ONE = {{(DW-2){1'b0}}, 1'b1};

    state_t        state;
    logic [1:0]    rr_ptr;
    logic [DW-2:0] rem;
    logic          inflight;
    logic          inflight_eop;

    logic [DW-1:0] b0_data, b1_data;
    logic          b0_sop, b0_eop, b1_sop, b1_eop;
    logic [1:0]    buf_cnt;

    logic [2:0]    req;
    logic [1:0]    o0, o1, o2;
    logic [1:0]    next_grant;
    logic          gnt_empty;
    logic [DW-1:0] gnt_data;
    logic          pop, push, push_sop;
    logic [2:0]    occ;
    logic          credit, allow, rd;
    logic          wd_fire;

    assign req = ~fifo_empty;

    always_comb begin
        gnt_empty = 1'b1;
        gnt_data  = '0;
        case (grant)
            2'd0: begin gnt_empty = fifo_empty[0]; gnt_data = fifo_dout_0; end
            2'd1: begin gnt_empty = fifo_empty[1]; gnt_data = fifo_dout_1; end
            2'd2: begin gnt_empty = fifo_empty[2]; gnt_data = fifo_dout_2; end
            default: ;
        endcase
    end

    // Search order starts just after the last-served FIFO.
    always_comb begin
        o0 = 2'd0;
        o1 = 2'd1;
        o2 = 2'd2;
        case (rr_ptr)
            2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: ;
        endcase
        next_grant = o2;
        if (req[o0])
            next_grant = o0;
        else if (req[o1])
            next_grant = o1;
    end

    // Credit counts the byte still in flight from the FIFO so the 2-entry buffer never overflows.
    assign pop    = vout & out_ready;
    assign occ    = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign credit = (occ < 3'd2);
    assign allow  = (state == S_HDR) || ((state == S_BODY) && (rem != '0));
    assign rd     = resetn & allow & ~gnt_empty & credit;

    assign read_enb = {rd && (grant == 2'd2), rd && (grant == 2'd1), rd && (grant == 2'd0)};

    assign push     = inflight;
    assign push_sop = (state == S_HWAIT);

    assign dout = b0_data;
    assign vout = (buf_cnt != 2'd0);
    assign sop  = vout & b0_sop;
    assign eop  = vout & b0_eop;
    assign busy = (state != S_IDLE);

`ifdef ROUTER_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt;

    assign wd_fire = (state == S_BODY) && !rd && gnt_empty && (rem != '0) &&
                     (wd_cnt == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wd_cnt <= '0;
            abort  <= 1'b0;
        end else begin
            abort <= wd_fire;
            if ((state != S_BODY) || rd || wd_fire)
                wd_cnt <= '0;
            else if (gnt_empty && (rem != '0))
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign abort   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            rr_ptr       <= 2'd2;
            grant        <= 2'b11;
            rem          <= '0;
            inflight     <= 1'b0;
            inflight_eop <= 1'b0;
            buf_cnt      <= 2'd0;
            b0_data      <= '0;
            b0_sop       <= 1'b0;
            b0_eop       <= 1'b0;
            b1_data      <= '0;
            b1_sop       <= 1'b0;
            b1_eop       <= 1'b0;
        end else begin
            inflight     <= rd;
            inflight_eop <= rd && (state == S_BODY) && (rem == REM_ONE);

            if (push && pop) begin
                if (buf_cnt == 2'd2) begin
                    b0_data <= b1_data;
                    b0_sop  <= b1_sop;
                    b0_eop  <= b1_eop;
                    b1_data <= gnt_data;
                    b1_sop  <= push_sop;
                    b1_eop  <= inflight_eop;
                end else begin
                    b0_data <= gnt_data;
                    b0_sop  <= push_sop;
                    b0_eop  <= inflight_eop;
                end
            end else if (push) begin
                if (buf_cnt == 2'd0) begin
                    b0_data <= gnt_data;
                    b0_sop  <= push_sop;
                    b0_eop  <= inflight_eop;
                end else begin
                    b1_data <= gnt_data;
                    b1_sop  <= push_sop;
                    b1_eop  <= inflight_eop;
                end
                buf_cnt <= buf_cnt + 2'd1;
            end else if (pop) begin
                b0_data <= b1_data;
                b0_sop  <= b1_sop;
                b0_eop  <= b1_eop;
                buf_cnt <= buf_cnt - 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (|req) begin
                        grant <= next_grant;
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (rd)
                        state <= S_HWAIT;
                end
                S_HWAIT: begin
                    rem   <= {1'b0, gnt_data[DW-1:2]} + REM_ONE;
                    state <= S_BODY;
                end
                S_BODY: begin
                    if (wd_fire)
                        state <= S_DRAIN;
                    else if (rd)
                        rem <= rem - REM_ONE;
                    else if ((rem == '0) && !inflight)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((buf_cnt == 2'd0) && !inflight) begin
                        rr_ptr <= grant;
                        grant  <= 2'b11;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_egress_arbiter.sv
// tb/tb_router_egress_arbiter.sv - directed bench for router_egress_arbiter with behavioural FIFOs and egress sink
module tb_router_egress_arbiter;
    logic       clk;
    logic       resetn;
    logic [2:0] fifo_empty;
    logic [7:0] fd0, fd1, fd2;
    logic       out_ready;
    logic [2:0] read_enb;
    logic [7:0] dout;
    logic       vout, sop, eop, busy, abort;
    logic [1:0] grant;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  q2[$];
    logic [11:0] log_q[$];
    logic [11:0] exp_q[$];
    int rdc0, rdc1, rdc2, abort_cnt;
    int errors, checks;

    router_egress_arbiter #(.DW(8), .TIMEOUT(30)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .fifo_empty (fifo_empty),
        .fifo_dout_0(fd0),
        .fifo_dout_1(fd1),
        .fifo_dout_2(fd2),
        .out_ready  (out_ready),
        .read_enb   (read_enb),
        .dout       (dout),
        .vout       (vout),
        .sop        (sop),
        .eop        (eop),
        .grant      (grant),
        .busy       (busy),
        .abort      (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] beat(input logic [1:0] g, input logic s, input logic e,
                                         input logic [7:0] d);
        return {g, s, e, d};
    endfunction

    // One clock: sample handshakes after inputs settle, then play FIFOs and sink at the edge.
    task automatic tick();
        logic [2:0]  r;
        logic        p, ab;
        logic [11:0] b;
        #1;
        r  = read_enb;
        p  = resetn && vout && out_ready;
        b  = {grant, sop, eop, dout};
        ab = abort;
        @(posedge clk);
        #1;
        if (r[0]) begin rdc0++; if (q0.size() > 0) fd0 = q0.pop_front(); end
        if (r[1]) begin rdc1++; if (q1.size() > 0) fd1 = q1.pop_front(); end
        if (r[2]) begin rdc2++; if (q2.size() > 0) fd2 = q2.pop_front(); end
        if (p) log_q.push_back(b);
        if (ab) abort_cnt++;
        fifo_empty = {q2.size() == 0, q1.size() == 0, q0.size() == 0};
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        repeat (4) tick();
        while (((q0.size() + q1.size() + q2.size()) != 0 || busy || vout) && n <= 400) begin
            tick();
            n++;
        end
        check({tag, " settle"}, 32'(n > 400), 32'd0);
    endtask

    task automatic wait_beats(input string tag, input int base, input int cnt);
        int n;
        n = 0;
        while ((log_q.size() - base) < cnt && n < 50) begin
            tick();
            n++;
        end
        check({tag, " beats seen"}, 32'(n < 50), 32'd1);
    endtask

    task automatic check_log(input string tag, input int base);
        check({tag, " count"}, log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size())
                check($sformatf("%s beat%0d", tag, i), log_q[base+i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    initial begin
        int lb, r0, r1, r2, a0;
        errors = 0; checks = 0;
        rdc0 = 0; rdc1 = 0; rdc2 = 0; abort_cnt = 0;
        resetn = 1'b0; out_ready = 1'b1; fifo_empty = 3'b111;
        fd0 = 8'h00; fd1 = 8'h00; fd2 = 8'h00;
        @(negedge clk);
        repeat (3) tick();

        check("rst read_enb", read_enb, 3'b000);
        check("rst vout", vout, 1'b0);
        check("rst sop_eop", {sop, eop}, 2'b00);
        check("rst dout", dout, 8'h00);
        check("rst grant", grant, 2'b11);
        check("rst busy", busy, 1'b0);
        check("rst abort", abort, 1'b0);
        resetn = 1'b1;
        tick();

        // single len-3 packet from FIFO1
        lb = log_q.size(); r0 = rdc0; r1 = rdc1; r2 = rdc2;
        q1.push_back(8'h0D); q1.push_back(8'hA1); q1.push_back(8'hA2);
        q1.push_back(8'hA3); q1.push_back(8'h5C);
        wait_done("t1");
        check("t1 reads fifo1", rdc1 - r1, 5);
        check("t1 reads others", (rdc0 - r0) + (rdc2 - r2), 0);
        exp_q = '{beat(2'd1, 1'b1, 1'b0, 8'h0D), beat(2'd1, 1'b0, 1'b0, 8'hA1),
                  beat(2'd1, 1'b0, 1'b0, 8'hA2), beat(2'd1, 1'b0, 1'b0, 8'hA3),
                  beat(2'd1, 1'b0, 1'b1, 8'h5C)};
        check_log("t1", lb);

        // round robin after reset, FIFO0 holds a second packet
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        lb = log_q.size();
        q0.push_back(8'h04); q0.push_back(8'h10); q0.push_back(8'h11);
        q0.push_back(8'h08); q0.push_back(8'h40); q0.push_back(8'h41); q0.push_back(8'h42);
        q1.push_back(8'h05); q1.push_back(8'h20); q1.push_back(8'h21);
        q2.push_back(8'h06); q2.push_back(8'h30); q2.push_back(8'h31);
        wait_done("t2");
        exp_q = '{beat(2'd0, 1'b1, 1'b0, 8'h04), beat(2'd0, 1'b0, 1'b0, 8'h10),
                  beat(2'd0, 1'b0, 1'b1, 8'h11),
                  beat(2'd1, 1'b1, 1'b0, 8'h05), beat(2'd1, 1'b0, 1'b0, 8'h20),
                  beat(2'd1, 1'b0, 1'b1, 8'h21),
                  beat(2'd2, 1'b1, 1'b0, 8'h06), beat(2'd2, 1'b0, 1'b0, 8'h30),
                  beat(2'd2, 1'b0, 1'b1, 8'h31),
                  beat(2'd0, 1'b1, 1'b0, 8'h08), beat(2'd0, 1'b0, 1'b0, 8'h40),
                  beat(2'd0, 1'b0, 1'b0, 8'h41), beat(2'd0, 1'b0, 1'b1, 8'h42)};
        check_log("t2", lb);

        // backpressure: sink stalls 5 cycles after the 2nd byte
        lb = log_q.size(); r0 = rdc0;
        q0.push_back(8'h10); q0.push_back(8'hB1); q0.push_back(8'hB2);
        q0.push_back(8'hB3); q0.push_back(8'hB4); q0.push_back(8'hE5);
        wait_beats("t3", lb, 2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3 hold%0d", i), {vout, dout}, {1'b1, 8'hB2});
        end
        check("t3 reads at stall", rdc0 - r0, 4);
        out_ready = 1'b1;
        wait_done("t3");
        check("t3 reads total", rdc0 - r0, 6);
        exp_q = '{beat(2'd0, 1'b1, 1'b0, 8'h10), beat(2'd0, 1'b0, 1'b0, 8'hB1),
                  beat(2'd0, 1'b0, 1'b0, 8'hB2), beat(2'd0, 1'b0, 1'b0, 8'hB3),
                  beat(2'd0, 1'b0, 1'b0, 8'hB4), beat(2'd0, 1'b0, 1'b1, 8'hE5)};
        check_log("t3", lb);

        // zero-length packet in FIFO2
        lb = log_q.size(); r2 = rdc2;
        q2.push_back(8'h02); q2.push_back(8'h77);
        wait_done("t4");
        check("t4 reads", rdc2 - r2, 2);
        exp_q = '{beat(2'd2, 1'b1, 1'b0, 8'h02), beat(2'd2, 1'b0, 1'b1, 8'h77)};
        check_log("t4", lb);

        // reset mid-packet; FIFO0 must win the first grant afterwards
        lb = log_q.size();
        q1.push_back(8'h15); q1.push_back(8'hC1); q1.push_back(8'hC2); q1.push_back(8'hC3);
        q1.push_back(8'hC4); q1.push_back(8'hC5); q1.push_back(8'hDA);
        wait_beats("t5", lb, 2);
        resetn = 1'b0;
        q0.push_back(8'h00); q0.push_back(8'h99);
        r1 = rdc1;
        tick();
        check("t5 no read in reset", rdc1 - r1, 0);
        check("t5 rst vout_sop_eop", {vout, sop, eop}, 3'b000);
        check("t5 rst dout", dout, 8'h00);
        check("t5 rst grant", grant, 2'b11);
        check("t5 rst busy", busy, 1'b0);
        resetn = 1'b1;
        lb = log_q.size();
        tick();
        check("t5 first grant", grant, 2'd0);
        q1.delete();
        wait_done("t5");
        check("t5 fifo1 untouched", rdc1 - r1, 0);
        exp_q = '{beat(2'd0, 1'b1, 1'b0, 8'h00), beat(2'd0, 1'b0, 1'b1, 8'h99)};
        check_log("t5", lb);

        // granted FIFO runs dry mid-packet
        lb = log_q.size(); a0 = abort_cnt;
        q0.push_back(8'h14); q0.push_back(8'hD1); q0.push_back(8'hD2);
        repeat (60) tick();
`ifdef ROUTER_ARB_TIMEOUT_EN
        check("t6 abort pulses", abort_cnt - a0, 1);
        check("t6 busy", busy, 1'b0);
        exp_q = '{beat(2'd0, 1'b1, 1'b0, 8'h14), beat(2'd0, 1'b0, 1'b0, 8'hD1),
                  beat(2'd0, 1'b0, 1'b0, 8'hD2)};
        check_log("t6", lb);
`else
        check("t6 abort pulses", abort_cnt - a0, 0);
        check("t6 busy waiting", busy, 1'b1);
        check("t6 partial beats", log_q.size() - lb, 3);
        q0.push_back(8'hD3); q0.push_back(8'hD4); q0.push_back(8'hD5); q0.push_back(8'hEE);
        wait_done("t6");
        exp_q = '{beat(2'd0, 1'b1, 1'b0, 8'h14), beat(2'd0, 1'b0, 1'b0, 8'hD1),
                  beat(2'd0, 1'b0, 1'b0, 8'hD2), beat(2'd0, 1'b0, 1'b0, 8'hD3),
                  beat(2'd0, 1'b0, 1'b0, 8'hD4), beat(2'd0, 1'b0, 1'b0, 8'hD5),
                  beat(2'd0, 1'b0, 1'b1, 8'hEE)};
        check_log("t6", lb);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
